byte_encode_stream: RTL and testbench

//  Sequential, streaming ByteEncode_d (Algorithm 5). It packs 256 coefficients per polynomial

---
 rtl/byte_encode_stream.sv | 141 ++++++++++++++
 tb/tb_byte_encode_stream.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_encode_stream.sv
// Streaming ByteEncode_d: packs 256 d-bit coefficients per polynomial into OUT_BYTES-wide words, LSB-first.
// Optional range check on accepted coefficients is enabled by defining BYTE_ENCODE_STREAM_RANGE_CHECK_EN.
module byte_encode_stream #(
    parameter int COEF_W    = 16,
    parameter int D_MAX     = 12,
    parameter int OUT_BYTES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [3:0]             d_i,
    output logic                   busy_o,
    input  logic [COEF_W-1:0]      coef_i,
    input  logic                   coef_valid_i,
    output logic                   coef_ready_o,
    output logic [8*OUT_BYTES-1:0] out_data_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   out_last_o,
    output logic                   done_o,
    output logic                   err_o
);
    localparam int OUT_W = 8 * OUT_BYTES;
    localparam int ACC_W = OUT_W + D_MAX - 1;
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam int OB_SH = $clog2(OUT_BYTES);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [3:0]         d_q, d_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic [8:0]         coef_cnt_q, coef_cnt_d;
    logic [9:0]         word_cnt_q, word_cnt_d;
    logic               done_q;

    logic               start_accept;
    logic               coef_fire;
    logic               out_fire;
    logic [COEF_W-1:0]  coef_mask;
    logic [COEF_W-1:0]  coef_bits;
    logic [9:0]         words_last;

    assign start_accept = (state_q == IDLE) && start_i && (d_i != 4'd0) && (d_i <= 4'(D_MAX));
    assign coef_mask    = ~({COEF_W{1'b1}} << d_q);
    assign coef_bits    = coef_i & coef_mask;
    // 32*d bytes per polynomial divided into OUT_BYTES-wide words
    assign words_last   = ((({6'd0, d_q}) << 5) >> OB_SH) - 10'd1;

    // All handshake outputs decode registered state only, so no input-to-output paths exist.
    assign busy_o       = (state_q != IDLE);
    assign coef_ready_o = (state_q == RUN) && (acc_cnt_q < CNT_W'(OUT_W));
    assign out_valid_o  = (acc_cnt_q >= CNT_W'(OUT_W));
    assign out_data_o   = acc_q[OUT_W-1:0];
    assign out_last_o   = out_valid_o && (word_cnt_q == words_last);
    assign done_o       = done_q;
    assign coef_fire    = coef_valid_i && coef_ready_o;
    assign out_fire     = out_valid_o && out_ready_i;

    always_comb begin
        state_d    = state_q;
        d_d        = d_q;
        acc_d      = acc_q;
        acc_cnt_d  = acc_cnt_q;
        coef_cnt_d = coef_cnt_q;
        word_cnt_d = word_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start_accept) begin
                    state_d    = RUN;
                    d_d        = d_i;
                    acc_d      = '0;
                    acc_cnt_d  = '0;
                    coef_cnt_d = '0;
                    word_cnt_d = '0;
                end
            end
            default: begin
                // Drain first so a same-cycle append lands at the post-shift fill level.
                if (out_fire) begin
                    acc_d      = acc_q >> OUT_W;
                    acc_cnt_d  = acc_cnt_q - CNT_W'(OUT_W);
                    word_cnt_d = word_cnt_q + 10'd1;
                end
                if (coef_fire) begin
                    acc_d      = acc_d | (ACC_W'(coef_bits) << acc_cnt_d);
                    acc_cnt_d  = acc_cnt_d + CNT_W'(d_q);
                    coef_cnt_d = coef_cnt_q + 9'd1;
                    if (coef_cnt_q == 9'd255) state_d = DRAIN;
                end
                if (out_fire && out_last_o) state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            d_q        <= '0;
            acc_q      <= '0;
            acc_cnt_q  <= '0;
            coef_cnt_q <= '0;
            word_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_q        <= d_d;
            acc_q      <= acc_d;
            acc_cnt_q  <= acc_cnt_d;
            coef_cnt_q <= coef_cnt_d;
            word_cnt_q <= word_cnt_d;
            done_q     <= out_fire && out_last_o;
        end
    end

`ifdef BYTE_ENCODE_STREAM_RANGE_CHECK_EN
    logic err_q;
    logic range_bad;

    // d = 12 carries values mod q = 3329; smaller d must fit in d bits
    assign range_bad = (d_q == 4'd12) ? (coef_i >= COEF_W'(3329))
                                      : ((coef_i & ~coef_mask) != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (start_accept) begin
            err_q <= 1'b0;
        end else if (coef_fire && range_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_byte_encode_stream.sv
// Self-checking bench for byte_encode_stream: random stimulus, bit-list reference model, scoreboard monitor.
module tb_byte_encode_stream;
    localparam int COEF_W    = 16;
    localparam int D_MAX     = 12;
    localparam int OUT_BYTES = 4;
    localparam int OUT_W     = 8 * OUT_BYTES;

    typedef enum int {K_ALT, K_MOD16, K_3328, K_FULL, K_INRANGE, K_RANGE_ERR} kind_t;
    typedef struct {
        logic [OUT_W-1:0] data;
        logic             last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              start_i = 1'b0;
    logic [3:0]        d_i = 4'd0;
    logic              busy_o;
    logic [COEF_W-1:0] coef_i = '0;
    logic              coef_valid_i = 1'b0;
    logic              coef_ready_o;
    logic [OUT_W-1:0]  out_data_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              out_last_o;
    logic              done_o;
    logic              err_o;

    byte_encode_stream #(.COEF_W(COEF_W), .D_MAX(D_MAX), .OUT_BYTES(OUT_BYTES)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .d_i(d_i), .busy_o(busy_o),
        .coef_i(coef_i), .coef_valid_i(coef_valid_i), .coef_ready_o(coef_ready_o),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_last_o(out_last_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

`ifdef BYTE_ENCODE_STREAM_RANGE_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   total_words = 0;
    int   done_seen = 0;
    int   poly_id = 0;
    int   stall_poly = -1;
    int   word_base = 0;
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: flatten coefficients into a stream of bits, then cut into words.
    function automatic void push_expected(input int d, input logic [COEF_W-1:0] c[256]);
        bit   bits[$];
        exp_t e;
        int   nw;
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < d; j++) bits.push_back(c[i][j]);
        nw = (256 * d) / OUT_W;
        for (int w = 0; w < nw; w++) begin
            e.data = '0;
            for (int b = 0; b < OUT_W; b++) e.data[b] = bits[w * OUT_W + b];
            e.last = (w == nw - 1);
            exp_q.push_back(e);
        end
    endfunction

    // Sink ready generator; optionally holds ready low 10 cycles while word 5 is pending.
    int stall_cycles = 0;
    always @(posedge clk) begin
        #1;
        if (stall_poly == poly_id && (total_words - word_base) == 5 && stall_cycles < 10) begin
            out_ready_i = 1'b0;
            stall_cycles++;
        end else begin
            out_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks hold behaviour.
    exp_t             mon_e;
    logic [OUT_W-1:0] prev_data;
    logic             prev_last;
    bit               prev_stall = 1'b0;
    always @(negedge clk) begin
        if (!rst_ni) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid_o), 64'(1'b1));
                check("hold_data", 64'(out_data_o), 64'(prev_data));
                check("hold_last", 64'(out_last_o), 64'(prev_last));
                check("hold_coef_ready", 64'(coef_ready_o), 64'(1'b0));
            end
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got 0x%0h, want no word", out_data_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("word_data", 64'(out_data_o), 64'(mon_e.data));
                    check("word_last", 64'(out_last_o), 64'(mon_e.last));
                end
                total_words++;
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_data  = out_data_o;
            prev_last  = out_last_o;
            if (done_o) done_seen++;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy_o), 64'(0));
        check({tag, "_coef_ready"}, 64'(coef_ready_o), 64'(0));
        check({tag, "_out_valid"}, 64'(out_valid_o), 64'(0));
        check({tag, "_out_data"}, 64'(out_data_o), 64'(0));
        check({tag, "_out_last"}, 64'(out_last_o), 64'(0));
        check({tag, "_done"}, 64'(done_o), 64'(0));
        check({tag, "_err"}, 64'(err_o), 64'(0));
    endtask

    task automatic run_poly(input int d, input kind_t kind, input bit rnd_valid, input bit rnd_ready,
                            input bit do_stall, input int abort_at, input bit poke_start);
        logic [COEF_W-1:0] c[256];
        int  idx, cycles, done_base;
        bit  fire;
        for (int i = 0; i < 256; i++) begin
            case (kind)
                K_ALT:       c[i] = (i % 2 == 0) ? 16'd1 : 16'd0;
                K_MOD16:     c[i] = 16'(i % 16);
                K_3328:      c[i] = 16'd3328;
                K_FULL:      c[i] = 16'($urandom);
                K_RANGE_ERR: c[i] = (i == 0) ? 16'h0400 : 16'($urandom_range(0, (1 << d) - 1));
                default:     c[i] = 16'($urandom_range(0, (1 << d) - 1));
            endcase
        end
        poly_id++;
        rand_ready = rnd_ready;
        if (do_stall) stall_poly = poly_id;
        word_base = total_words;
        done_base = done_seen;
        push_expected(d, c);

        @(posedge clk); #1;
        start_i = 1'b1;
        d_i     = 4'(d);
        @(posedge clk); #1;
        start_i = 1'b0;
        check("busy_after_start", 64'(busy_o), 64'(1));

        idx = 0;
        cycles = 0;
        while (idx < 256 && cycles < 20000) begin
            if (idx == abort_at) break;
            start_i      = (poke_start && idx == 50);
            d_i          = (poke_start && idx == 50) ? 4'd3 : 4'(d);
            coef_i       = c[idx];
            coef_valid_i = rnd_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            fire = coef_valid_i && coef_ready_o;
            @(posedge clk); #1;
            if (fire) idx++;
            cycles++;
        end
        coef_valid_i = 1'b0;
        start_i      = 1'b0;
        if (idx == abort_at) return;
        check("coefs_accepted", 64'(idx), 64'(256));

        cycles = 0;
        while (done_seen == done_base && cycles < 5000) begin
            @(posedge clk); #1;
            cycles++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", 64'(done_seen - done_base), 64'(1));
        check("words_emitted", 64'(total_words - word_base), 64'((256 * d) / OUT_W));
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        check("busy_after_done", 64'(busy_o), 64'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_ni = 1'b1;
        @(posedge clk); #1;

        run_poly(1, K_ALT, 0, 0, 0, -1, 0);
        run_poly(4, K_MOD16, 0, 0, 0, -1, 0);
        run_poly(12, K_3328, 0, 0, 0, -1, 0);
        check("err_3328", 64'(err_o), 64'(0));

        // d=12 with a 10-cycle sink stall on word 5 and an ignored start mid-stream
        run_poly(12, K_INRANGE, 1, 0, 1, -1, 1);
        check("stall_applied", 64'(stall_cycles), 64'(10));

        // reset after coefficient 100, then a clean d=1 polynomial
        run_poly(1, K_ALT, 0, 0, 0, 100, 0);
        rst_ni = 1'b0;
        #1;
        check_all_zero("mid_reset");
        exp_q.delete();
        @(posedge clk); #1;
        rst_ni = 1'b1;
        run_poly(1, K_ALT, 0, 0, 0, -1, 0);

        // illegal d values are ignored
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            start_i = 1'b1;
            d_i     = (k == 0) ? 4'd0 : ((k == 1) ? 4'd13 : 4'd15);
            @(posedge clk); #1;
            start_i = 1'b0;
            check("illegal_d_busy", 64'(busy_o), 64'(0));
        end

        run_poly(10, K_RANGE_ERR, 1, 1, 0, -1, 0);
        check("err_range", 64'(err_o), 64'(EXP_ERR));
        run_poly(5, K_INRANGE, 1, 1, 0, -1, 0);
        check("err_cleared", 64'(err_o), 64'(0));

        run_poly(7, K_FULL, 1, 1, 0, -1, 0);
        for (int n = 0; n < 6; n++)
            run_poly($urandom_range(1, D_MAX), K_INRANGE, 1, 1, 0, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
